// File: rtl/mips_cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer for the bus-based MIPS CPU.
// Steps FETCH -> EXEC -> [MEM | MULDIV] and gates decoder strobes into the commit cycle.
module mips_cpu_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       waitrequest,
    input  logic       dec_mem_read,
    input  logic       dec_mem_write,
    input  logic       dec_muldiv,
    input  logic       dec_reg_write,
    input  logic       muldiv_done,
    input  logic       pc_next_zero,
    output logic       bus_read,
    output logic       bus_write,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       muldiv_start,
    output logic       active,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EXEC   = 3'd1,
        S_MEM    = 3'd2,
        S_MULDIV = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t r_state;

    logic w_bus_read;
    logic w_bus_write;
    logic w_addr_sel;
    logic w_ir_write;
    logic w_pc_write;
    logic w_reg_write;
    logic w_muldiv_start;
    logic w_active;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_bus_read     = 1'b0;
        w_bus_write    = 1'b0;
        w_addr_sel     = 1'b0;
        w_ir_write     = 1'b0;
        w_pc_write     = 1'b0;
        w_reg_write    = 1'b0;
        w_muldiv_start = 1'b0;
        w_active       = 1'b1;
        case (r_state)
            S_FETCH: begin
                w_bus_read = 1'b1;
                w_ir_write = !waitrequest;
            end
            S_EXEC: begin
                if (!dec_mem_read && !dec_mem_write) begin
                    if (dec_muldiv) begin
                        w_muldiv_start = 1'b1;
                    end else begin
                        w_pc_write  = 1'b1;
                        w_reg_write = dec_reg_write;
                    end
                end
            end
            S_MEM: begin
                // Read wins when both mem flags are set, so a store is "mem op that is not a load".
                w_addr_sel  = 1'b1;
                w_bus_read  = dec_mem_read;
                w_bus_write = !dec_mem_read;
                if (!waitrequest) begin
                    w_pc_write  = 1'b1;
                    w_reg_write = dec_mem_read & dec_reg_write;
                end
            end
            S_MULDIV: begin
                w_pc_write = muldiv_done;
            end
            default: begin
                w_active = 1'b0;
            end
        endcase
    end

    // Reset masks everything combinationally so strobes drop in the reset cycle itself.
    assign bus_read     = w_bus_read     & !reset;
    assign bus_write    = w_bus_write    & !reset;
    assign addr_sel     = w_addr_sel     & !reset;
    assign ir_write     = w_ir_write     & !reset;
    assign pc_write     = w_pc_write     & !reset;
    assign reg_write    = w_reg_write    & !reset;
    assign muldiv_start = w_muldiv_start & !reset;
    assign active       = w_active       & !reset;
    assign state        = reset ? 3'd0 : r_state;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  if (!waitrequest) r_state <= S_EXEC;
                S_EXEC: begin
                    if (dec_mem_read || dec_mem_write) r_state <= S_MEM;
                    else if (dec_muldiv)               r_state <= S_MULDIV;
                end
                S_MEM:    r_state <= S_MEM;
                S_MULDIV: r_state <= S_MULDIV;
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_HALTED;
            endcase
            // Any commit leaves the instruction; later assignment overrides the hold above.
            if (w_pc_write) r_state <= pc_next_zero ? S_HALTED : S_FETCH;
        end
    end

endmodule

// File: tb/tb_mips_cpu_seq_ctrl.sv
// Randomized scoreboard bench for mips_cpu_seq_ctrl: per-instruction expectations
// are queued by the driver and matched by a monitor at each pc_write commit.
module tb_mips_cpu_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       waitrequest;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_muldiv;
    logic       dec_reg_write;
    logic       muldiv_done;
    logic       pc_next_zero;
    logic       bus_read;
    logic       bus_write;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       muldiv_start;
    logic       active;
    logic [2:0] state;

    mips_cpu_seq_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .waitrequest   (waitrequest),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_muldiv    (dec_muldiv),
        .dec_reg_write (dec_reg_write),
        .muldiv_done   (muldiv_done),
        .pc_next_zero  (pc_next_zero),
        .bus_read      (bus_read),
        .bus_write     (bus_write),
        .addr_sel      (addr_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .muldiv_start  (muldiv_start),
        .active        (active),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction kinds: 0 ALU/branch, 1 load, 2 store, 3 read+write (load), 4 mul/div.
    typedef struct {
        int lat;
        int fetch_lat;
        bit rw;
        int n_read;
        int n_write;
        int n_addr;
        int n_start;
        int cstate;
        bit halt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- monitor ----------------
    int cyc, n_read, n_write, n_addr, n_start, n_ir, n_reg, ir_cyc;
    bit halted, after_commit, prev_reset;

    task automatic clear_acc();
        cyc = 0; n_read = 0; n_write = 0; n_addr = 0;
        n_start = 0; n_ir = 0; n_reg = 0; ir_cyc = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("reset_outputs",
                  {active, state, addr_sel, bus_read, bus_write, ir_write, pc_write, reg_write, muldiv_start},
                  32'd0);
            clear_acc();
            halted = 1'b0;
            after_commit = 1'b0;
            prev_reset = 1'b1;
        end else begin
            if (prev_reset)
                check("release_first_cycle", {active, state, bus_read}, {1'b1, 3'd0, 1'b1});
            prev_reset = 1'b0;
            if (halted) begin
                check("halted_quiet",
                      {active, state, addr_sel, bus_read, bus_write, ir_write, pc_write, reg_write, muldiv_start},
                      {1'b0, 3'd4, 7'd0});
            end else begin
                check("active_running", active, 1'b1);
                if (after_commit)
                    check("next_fetch", {state, bus_read, addr_sel}, {3'd0, 1'b1, 1'b0});
                after_commit = 1'b0;
                cyc++;
                n_read  += int'(bus_read);
                n_write += int'(bus_write);
                n_addr  += int'(addr_sel);
                n_start += int'(muldiv_start);
                n_reg   += int'(reg_write);
                if (ir_write) begin
                    n_ir++;
                    ir_cyc = cyc;
                end
                if (pc_write) begin
                    check("commit_queue_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("latency",      cyc,       e.lat);
                        check("fetch_cycle",  ir_cyc,    e.fetch_lat);
                        check("ir_pulses",    n_ir,      1);
                        check("reg_at_commit", reg_write, e.rw);
                        check("reg_pulses",   n_reg,     int'(e.rw));
                        check("read_cycles",  n_read,    e.n_read);
                        check("write_cycles", n_write,   e.n_write);
                        check("addr_alu_cycles", n_addr, e.n_addr);
                        check("muldiv_starts", n_start,  e.n_start);
                        check("commit_state", state,     e.cstate);
                        halted = e.halt;
                        after_commit = !e.halt;
                    end
                    clear_acc();
                end else if (cyc > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL commit_timeout: got no pc_write in %0d cycles expected a commit", cyc);
                    clear_acc();
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input bit w, input bit mr, input bit mwr, input bit md,
                        input bit rw, input bit done, input bit pnz);
        waitrequest   = w;
        dec_mem_read  = mr;
        dec_mem_write = mwr;
        dec_muldiv    = md;
        dec_reg_write = rw;
        muldiv_done   = done;
        pc_next_zero  = pnz;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_rand(input bit w);
        tick(w, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < n; i++) tick_rand(rnd());
        reset = 1'b0;
    endtask

    task automatic run_instr(input int kind, input int fw, input int mw, input int k,
                             input bit rw, input bit halt);
        exp_t e;
        bit   mr, mwr, md, is_mem;
        mr     = (kind == 1) || (kind == 3);
        mwr    = (kind == 2) || (kind == 3);
        md     = (kind == 4) ? 1'b1 : ((kind == 0) ? 1'b0 : rnd());
        is_mem = mr || mwr;
        e.fetch_lat = fw + 1;
        e.lat       = fw + 2 + (is_mem ? mw + 1 : 0) + ((kind == 4) ? k : 0);
        e.rw        = (kind == 0 || mr) ? rw : 1'b0;
        e.n_read    = fw + 1 + (mr ? mw + 1 : 0);
        e.n_write   = (is_mem && !mr) ? mw + 1 : 0;
        e.n_addr    = is_mem ? mw + 1 : 0;
        e.n_start   = (kind == 4) ? 1 : 0;
        e.cstate    = is_mem ? 2 : ((kind == 4) ? 3 : 1);
        e.halt      = halt;
        sb.push_back(e);

        for (int i = 0; i < fw; i++) tick_rand(1'b1);
        tick_rand(1'b0);
        if (kind == 0) begin
            tick(rnd(), 1'b0, 1'b0, 1'b0, rw, rnd(), halt);
        end else if (kind == 4) begin
            tick(rnd(), 1'b0, 1'b0, 1'b1, rw, rnd(), rnd());
            for (int i = 0; i < k - 1; i++) tick(rnd(), 1'b0, 1'b0, 1'b1, rw, 1'b0, rnd());
            tick(rnd(), 1'b0, 1'b0, 1'b1, rw, 1'b1, halt);
        end else begin
            tick(rnd(), mr, mwr, md, rw, rnd(), rnd());
            for (int i = 0; i < mw; i++) tick(1'b1, mr, mwr, md, rw, rnd(), rnd());
            tick(1'b0, mr, mwr, md, rw, rnd(), halt);
        end
    endtask

    // Start an instruction, stall it, then reset before it can commit.
    task automatic run_abandon(input int kind);
        tick_rand(1'b0);
        if (kind == 4) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            for (int i = 0; i < 2; i++) tick(rnd(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        end else begin
            tick(1'b0, kind == 1, kind == 2, 1'b0, 1'b1, 1'b0, 1'b1);
            for (int i = 0; i < 2; i++) tick(1'b1, kind == 1, kind == 2, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        do_reset(1);
    endtask

    task automatic halted_idle();
        for (int i = 0; i < 20; i++) tick_rand(1'(i));
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        waitrequest = 1'b0; dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_muldiv = 1'b0;
        dec_reg_write = 1'b0; muldiv_done = 1'b0; pc_next_zero = 1'b0;
        clear_acc();
        halted = 1'b0; after_commit = 1'b0; prev_reset = 1'b0;
        do_reset(3);

        // Directed program: ADDU, LW (3 stalls), SW, DIV (k=5), JR to zero.
        run_instr(0, 0, 0, 0, 1'b1, 1'b0);
        run_instr(1, 0, 3, 0, 1'b1, 1'b0);
        run_instr(2, 0, 0, 0, 1'b0, 1'b0);
        run_instr(4, 0, 0, 5, 1'b1, 1'b0);
        run_instr(0, 0, 0, 0, 1'b0, 1'b1);
        halted_idle();

        // Reset during a stalled fetch, then the fetch restarts cleanly.
        do_reset(2);
        tick_rand(1'b1);
        tick_rand(1'b1);
        do_reset(1);
        run_instr(0, 1, 0, 0, 1'b1, 1'b0);

        // Abandon load, store and mul/div mid-flight.
        run_abandon(1);
        run_abandon(2);
        run_abandon(4);

        // Random programs, each ending in a halting commit.
        for (int p = 0; p < 8; p++) begin
            int n;
            n = int'($urandom_range(4, 15));
            for (int i = 0; i < n; i++) begin
                int fw, mw;
                fw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
                mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
                run_instr(int'($urandom_range(0, 4)), fw, mw, int'($urandom_range(1, 6)),
                          rnd(), i == n - 1);
            end
            halted_idle();
            do_reset(2);
        end

        tick_rand(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
